// File: rtl/rr_burst_scheduler_if.sv
// rtl/rr_burst_scheduler_if.sv - requester and beat handshake bundle for rr_burst_scheduler
interface rr_burst_scheduler_if #(
    parameter int N   = 4,
    parameter int LW  = 4,
    parameter int IDW = 2
);
    logic [N-1:0]    req_i;
    logic [N*LW-1:0] len_i;
    logic [N-1:0]    gnt_o;
    logic [IDW-1:0]  gnt_id_o;
    logic            beat_valid_o;
    logic            beat_ready_i;
    logic            last_o;
    logic            busy_o;

    // Scheduler side: takes requests and ready, drives grant and beat strobes
    modport master (
        input  req_i, len_i, beat_ready_i,
        output gnt_o, gnt_id_o, beat_valid_o, last_o, busy_o
    );

    // Environment side: requesters and the shared resource
    modport slave (
        output req_i, len_i, beat_ready_i,
        input  gnt_o, gnt_id_o, beat_valid_o, last_o, busy_o
    );
endinterface

// File: rtl/rr_burst_scheduler.sv
// rtl/rr_burst_scheduler.sv - round-robin burst scheduler for one shared beat port
module rr_burst_scheduler #(
    parameter int N   = 4,
    parameter int LW  = 4,
    parameter int IDW = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    rr_burst_scheduler_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q;
    logic [N-1:0]   gnt_q;
    logic [IDW-1:0] gnt_id_q;
    logic [LW-1:0]  cnt_q;
    logic [N-1:0]   mask_q;
    logic           beat_valid_q;
    logic           last_q;
    logic           busy_q;

    logic [N-1:0]   masked_req;
    logic [N-1:0]   pick_req;
    logic [IDW-1:0] win_id;
    logic [N-1:0]   win_oh;
    logic [N-1:0]   mask_d;
    logic [LW-1:0]  win_len;
    logic           any_req;

    // Winner selection: lowest index among masked requests, else among raw requests
    always_comb begin
        masked_req = bus.req_i & mask_q;
        pick_req   = (masked_req != '0) ? masked_req : bus.req_i;
        any_req    = (bus.req_i != '0);
        win_id     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick_req[i]) begin
                win_id = IDW'(i);
            end
        end
        win_oh         = '0;
        win_oh[win_id] = 1'b1;
        // The winner and everything below it drop to lowest priority next time
        mask_d = '0;
        for (int i = 0; i < N; i++) begin
            mask_d[i] = (i > int'(win_id));
        end
        win_len = bus.len_i[int'(win_id)*LW +: LW];
    end

    // Burst FSM with registered grant, beat strobes and fairness mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            cnt_q        <= '0;
            mask_q       <= '1;
            beat_valid_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q      <= BUSY;
                        gnt_q        <= win_oh;
                        gnt_id_q     <= win_id;
                        cnt_q        <= win_len;
                        mask_q       <= mask_d;
                        beat_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        last_q       <= (win_len == '0);
                    end
                end
                BUSY: begin
                    if (bus.beat_ready_i) begin
                        if (cnt_q != '0) begin
                            cnt_q  <= cnt_q - LW'(1);
                            last_q <= (cnt_q == LW'(1));
                        end else if (any_req) begin
                            // Back-to-back regrant on the final beat, no bubble
                            gnt_q    <= win_oh;
                            gnt_id_q <= win_id;
                            cnt_q    <= win_len;
                            mask_q   <= mask_d;
                            last_q   <= (win_len == '0);
                        end else begin
                            state_q      <= IDLE;
                            gnt_q        <= '0;
                            gnt_id_q     <= '0;
                            beat_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            last_q       <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.gnt_id_o     = gnt_id_q;
    assign bus.beat_valid_o = beat_valid_q;
    assign bus.last_o       = last_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_rr_burst_scheduler.sv
// tb/tb_rr_burst_scheduler.sv - directed self-checking bench for rr_burst_scheduler
module tb_rr_burst_scheduler;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    rr_burst_scheduler_if #(.N(4), .LW(4), .IDW(2)) bus ();

    rr_burst_scheduler #(.N(4), .LW(4), .IDW(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int k, input logic [3:0] v);
        bus.len_i[k*4 +: 4] = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n          = 1'b0;
        bus.req_i        = '0;
        bus.len_i        = '0;
        bus.beat_ready_i = 1'b1;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    logic [3:0] exp_seq [5];
    logic [1:0] id_seq  [5];
    logic       rdy_seq [7];
    int         exp_cnt;
    int         beats;

    initial begin
        total            = 0;
        bad              = 0;
        reset_n          = 1'b0;
        bus.req_i        = '0;
        bus.len_i        = '0;
        bus.beat_ready_i = 1'b1;
        #12;

        // Reset state
        check("rst_gnt", bus.gnt_o, 4'b0000);
        check("rst_id", bus.gnt_id_o, 0);
        check("rst_valid", bus.beat_valid_o, 0);
        check("rst_last", bus.last_o, 0);
        check("rst_busy", bus.busy_o, 0);
        do_reset();

        // 1: single 3-beat burst from requester 0
        bus.req_i = 4'b0001;
        set_len(0, 4'd2);
        step();
        check("t1_gnt", bus.gnt_o, 4'b0001);
        check("t1_valid", bus.beat_valid_o, 1);
        check("t1_last_b1", bus.last_o, 0);
        bus.req_i = 4'b0000;
        step();
        check("t1_last_b2", bus.last_o, 0);
        check("t1_gnt_b2", bus.gnt_o, 4'b0001);
        step();
        check("t1_last_b3", bus.last_o, 1);
        check("t1_valid_b3", bus.beat_valid_o, 1);
        step();
        check("t1_idle_gnt", bus.gnt_o, 4'b0000);
        check("t1_idle_valid", bus.beat_valid_o, 0);
        check("t1_idle_busy", bus.busy_o, 0);

        // 2: all requesting single beats rotate with no gap
        do_reset();
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        id_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus.req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t2_gnt%0d", i), bus.gnt_o, exp_seq[i]);
            check($sformatf("t2_id%0d", i), bus.gnt_id_o, id_seq[i]);
            check($sformatf("t2_busy%0d", i), bus.busy_o, 1);
            check($sformatf("t2_last%0d", i), bus.last_o, 1);
        end
        bus.req_i = 4'b0000;
        step();
        check("t2_idle", bus.gnt_o, 4'b0000);

        // 3: after requester 1, priority moves to 2 then wraps to 0
        do_reset();
        bus.req_i = 4'b0010;
        set_len(1, 4'd3);
        step();
        check("t3_gnt1", bus.gnt_o, 4'b0010);
        bus.req_i = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t3_hold%0d", i), bus.gnt_o, 4'b0010);
        end
        check("t3_last", bus.last_o, 1);
        step();
        check("t3_gnt2", bus.gnt_o, 4'b0100);
        check("t3_id2", bus.gnt_id_o, 2);
        step();
        check("t3_gnt0", bus.gnt_o, 4'b0001);
        bus.req_i = 4'b0000;
        step();
        step();
        check("t3_idle", bus.busy_o, 0);

        // 4: ready toggling, 4 beats accepted, last only on the 4th
        do_reset();
        bus.req_i = 4'b0001;
        set_len(0, 4'd3);
        step();
        bus.req_i = 4'b0000;
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_cnt = 3;
        beats   = 0;
        for (int i = 0; i < 7; i++) begin
            bus.beat_ready_i = rdy_seq[i];
            check($sformatf("t4_gnt%0d", i), bus.gnt_o, 4'b0001);
            check($sformatf("t4_last%0d", i), bus.last_o, (exp_cnt == 0));
            if (bus.beat_valid_o && rdy_seq[i]) begin
                beats++;
                exp_cnt--;
            end
            step();
        end
        check("t4_beats", beats, 4);
        check("t4_idle", bus.beat_valid_o, 0);
        bus.beat_ready_i = 1'b1;

        // 5: async reset mid-burst, then requester 3 wins
        do_reset();
        bus.req_i = 4'b0001;
        set_len(0, 4'd3);
        step();
        bus.req_i = 4'b0000;
        step();
        check("t5_pre_busy", bus.busy_o, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_rst_gnt", bus.gnt_o, 4'b0000);
        check("t5_rst_valid", bus.beat_valid_o, 0);
        check("t5_rst_busy", bus.busy_o, 0);
        bus.req_i = 4'b1000;
        #2;
        reset_n = 1'b1;
        step();
        check("t5_gnt3", bus.gnt_o, 4'b1000);
        check("t5_id3", bus.gnt_id_o, 3);
        bus.req_i = 4'b0000;
        step();

        // 6: requester drops req and len changes mid-burst
        do_reset();
        bus.req_i = 4'b0100;
        set_len(2, 4'd2);
        step();
        check("t6_gnt", bus.gnt_o, 4'b0100);
        bus.req_i = 4'b0000;
        set_len(2, 4'd7);
        step();
        check("t6_hold1", bus.gnt_o, 4'b0100);
        check("t6_last1", bus.last_o, 0);
        step();
        check("t6_hold2", bus.gnt_o, 4'b0100);
        check("t6_last2", bus.last_o, 1);
        step();
        check("t6_idle", bus.gnt_o, 4'b0000);
        check("t6_idle_busy", bus.busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_burst_scheduler.md
Name: rr_burst_scheduler

Overview:
Shares one burst-capable resource port between N requesters using round-robin priority. A winning requester holds the grant for its whole burst. The block sequences each beat over a valid/ready handshake with the resource. Fairness rotates after every completed burst, and back-to-back bursts run with no idle cycle. It sits between the requester-side request lines and the shared resource's beat interface.

Parameters:
N, 4, number of requesters (2..16)
LW, 4, width of the per-requester burst-length field; max burst = 2^LW beats
IDW, 2, width of gnt_id_o; must equal ceil(log2(N))

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_i  input  N  per-requester burst request; held high until granted
len_i  input  N*LW  per-requester burst length minus 1; requester k uses bits [k*LW +: LW]
gnt_o  output  N  one-hot registered grant; all zero when idle
gnt_id_o  output  IDW  binary index of the granted requester; 0 when idle
beat_valid_o  output  1  a beat is offered to the resource
beat_ready_i  input  1  resource accepts the current beat
last_o  output  1  the current beat is the final beat of the burst (qualified by beat_valid_o)
busy_o  output  1  a burst is in progress (state BUSY)

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, gnt_o=0, gnt_id_o=0, beat_valid_o=0, last_o=0, busy_o=0, beat counter=0, priority mask=all ones (requester 0 highest).
- Reset asserted mid-burst: the burst is abandoned immediately. There is no completion beat.
- Arbitration (combinational, used only at decision points):
  - masked_req = req_i & mask.
  - If masked_req != 0, the winner is the lowest set index of masked_req. Otherwise it is the lowest set index of raw req_i.
- Mask update on granting index k: mask = bits strictly above k set, all others cleared. When k = N-1, the mask becomes all zero, which forces a fallback to raw req_i.
- FSM state IDLE:
  - Outputs beat_valid_o=0 and gnt_o=0.
  - If req_i != 0 at a clock edge: register the winner into gnt_o/gnt_id_o, load the counter with the winner's len_i, update the mask, go to BUSY.
  - Grant latency from req_i rising in IDLE is 1 cycle.
- FSM state BUSY:
  - Outputs beat_valid_o=1 and busy_o=1. last_o=1 when counter==0.
  - On beat_valid_o & beat_ready_i with counter>0: decrement the counter.
  - On beat_valid_o & beat_ready_i with counter==0 (last beat):
    - If req_i contains any request, regrant in the same edge using the updated mask and stay in BUSY. There is no bubble between bursts.
    - Otherwise clear gnt_o and go to IDLE.
  - beat_ready_i low: hold all state. beat_valid_o stays high; the valid/ready handshake is never withdrawn.
- The grant is never revoked mid-burst. A requester dropping req_i during its own burst has no effect. req_i changes of other requesters matter only at decision points.
- len_i is sampled only in the grant cycle. Later changes are ignored for that burst.
- The requester just served is lowest priority at the next decision, even if its req_i stays high. This rule applies whenever that requester's index is >= every other pending index, or when other requests sit above it in the mask.
- gnt_o is always one-hot or zero. gnt_id_o always matches gnt_o.
- Counter width is LW. A burst of 2^LW beats uses len=all ones, with no overflow.

Test Plan:
1. Reset, then req_i=0001, len0=2, beat_ready_i=1 -> gnt_o=0001 one cycle after the request; 3 beats; last_o on beat 3; returns to IDLE; gnt_o=0.
2. req_i=1111 held, all len=0, beat_ready_i=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles with no idle gap.
3. Requester 1 granted with len1=3; req_i=0111 throughout -> after the requester 1 burst the next grant is 0100 (index 2), then 0001.
4. Burst len=3 with beat_ready_i toggling 1,0,0,1,1,0,1 -> exactly 4 accepted beats; counter and gnt_o hold during ready-low cycles; last_o only on the 4th beat.
5. Mid-burst, deassert reset_n asynchronously (between clock edges) -> gnt_o, beat_valid_o and busy_o go to 0 immediately; after release with req_i=1000, requester 3 is granted next.
6. Requester 2 drops req_i after its grant and len_i changes mid-burst -> the burst completes with the originally sampled length; the grant is held throughout.
